// File: rtl/mmio_hub_if.sv
// Register bus between a CPU-side master and mmio_hub.
// Requests are one per cycle: io_cs && io_read (or io_write) is a request,
// there is no stall. io_rvalid is a one-cycle pulse exactly one cycle after
// each accepted read and qualifies io_rdata.
interface mmio_hub_if #(
  parameter int AW = 4
) ();
  logic          io_cs;
  logic          io_read;
  logic          io_write;
  logic [AW-1:0] io_addr;
  logic [31:0]   io_wdata;
  logic [31:0]   io_rdata;
  logic          io_rvalid;

  modport master (
    output io_cs, io_read, io_write, io_addr, io_wdata,
    input  io_rdata, io_rvalid
  );

  modport slave (
    input  io_cs, io_read, io_write, io_addr, io_wdata,
    output io_rdata, io_rvalid
  );
endinterface

// File: rtl/mmio_hub.sv
// Memory-mapped LED/switch hub: per channel LED, debounced SW, sticky EDGE
// flags (W1C) and CTRL (irq enable, LED mirror), with a registered read port.
module mmio_hub #(
  parameter int NCH       = 3,
  parameter int CH_W      = 8,
  parameter int DB_CYCLES = 4
) (
  input  logic                clock,
  input  logic                rst,
  mmio_hub_if.slave           bus,
  input  logic [NCH*CH_W-1:0] switch_i,
  output logic [NCH*CH_W-1:0] leds_o,
  output logic                irq
);

  localparam int AW    = $clog2(NCH) + 2;
  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  // The counter holds the run length minus one, so it saturates at DB_CYCLES-1.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  localparam logic [1:0] REG_LED  = 2'd0;
  localparam logic [1:0] REG_SW   = 2'd1;
  localparam logic [1:0] REG_EDGE = 2'd2;
  localparam logic [1:0] REG_CTRL = 2'd3;

  logic [NCH*CH_W-1:0] sync1_q, sync1_d;
  logic [NCH*CH_W-1:0] sync2_q, sync2_d;
  logic [NCH*CH_W-1:0] prev_q,  prev_d;
  logic [CNT_W-1:0]    cnt_q  [NCH];
  logic [CNT_W-1:0]    cnt_d  [NCH];
  logic [CH_W-1:0]     sw_q   [NCH];
  logic [CH_W-1:0]     sw_d   [NCH];
  logic [CH_W-1:0]     edge_q [NCH];
  logic [CH_W-1:0]     edge_d [NCH];
  logic [CH_W-1:0]     led_q  [NCH];
  logic [CH_W-1:0]     led_d  [NCH];
  logic [1:0]          ctrl_q [NCH];
  logic [1:0]          ctrl_d [NCH];
  logic [NCH*CH_W-1:0] leds_q, leds_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                rvalid_q, rvalid_d;
  logic                irq_q, irq_d;

  logic [AW-1:0] addr;
  logic [1:0]    reg_sel;
  int            ch_idx;
  logic          rd_en;
  logic          wr_en;
  logic          unused_wdata;

  assign addr         = bus.io_addr;
  assign reg_sel      = addr[1:0];
  assign ch_idx       = int'(addr >> 2);
  assign rd_en        = bus.io_cs & bus.io_read;
  assign wr_en        = bus.io_cs & bus.io_write;
  assign unused_wdata = &{1'b0, bus.io_wdata};

  // Synchroniser plus per-channel stability counter; SW follows the sample
  // only after it has held for DB_CYCLES consecutive cycles.
  always_comb begin
    sync1_d = switch_i;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
    for (int c = 0; c < NCH; c++) begin
      if (sync2_q[c*CH_W +: CH_W] != prev_q[c*CH_W +: CH_W]) begin
        cnt_d[c] = '0;
      end else if (cnt_q[c] != CNT_MAX) begin
        cnt_d[c] = cnt_q[c] + 1'b1;
      end else begin
        cnt_d[c] = cnt_q[c];
      end
      if (cnt_d[c] == CNT_MAX) begin
        sw_d[c] = sync2_q[c*CH_W +: CH_W];
      end else begin
        sw_d[c] = sw_q[c];
      end
    end
  end

  // Register writes; a fresh SW change overrides a same-cycle W1C on EDGE.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      led_d[c]  = led_q[c];
      ctrl_d[c] = ctrl_q[c];
      edge_d[c] = edge_q[c];
      if (wr_en && (ch_idx == c)) begin
        case (reg_sel)
          REG_LED:  led_d[c]  = bus.io_wdata[CH_W-1:0];
          REG_EDGE: edge_d[c] = edge_q[c] & ~bus.io_wdata[CH_W-1:0];
          REG_CTRL: ctrl_d[c] = bus.io_wdata[1:0];
          default:  ;
        endcase
      end
      edge_d[c] = edge_d[c] | (sw_d[c] ^ sw_q[c]);
    end
  end

  // Read port returns pre-write state; unmapped channels read as zero.
  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    if (rd_en) begin
      rvalid_d = 1'b1;
      rdata_d  = '0;
      for (int c = 0; c < NCH; c++) begin
        if (ch_idx == c) begin
          case (reg_sel)
            REG_LED:  rdata_d = 32'(led_q[c]);
            REG_SW:   rdata_d = 32'(sw_q[c]);
            REG_EDGE: rdata_d = 32'(edge_q[c]);
            REG_CTRL: rdata_d = {30'b0, ctrl_q[c]};
            default:  rdata_d = '0;
          endcase
        end
      end
    end
  end

  always_comb begin
    leds_d = '0;
    irq_d  = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      leds_d[c*CH_W +: CH_W] = ctrl_q[c][1] ? sw_q[c] : led_q[c];
      irq_d = irq_d | (ctrl_q[c][0] & (|edge_q[c]));
    end
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      sync1_q  <= '0;
      sync2_q  <= '0;
      prev_q   <= '0;
      leds_q   <= '0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        cnt_q[c]  <= '0;
        sw_q[c]   <= '0;
        edge_q[c] <= '0;
        led_q[c]  <= '0;
        ctrl_q[c] <= '0;
      end
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      prev_q   <= prev_d;
      leds_q   <= leds_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      irq_q    <= irq_d;
      for (int c = 0; c < NCH; c++) begin
        cnt_q[c]  <= cnt_d[c];
        sw_q[c]   <= sw_d[c];
        edge_q[c] <= edge_d[c];
        led_q[c]  <= led_d[c];
        ctrl_q[c] <= ctrl_d[c];
      end
    end
  end

  assign leds_o        = leds_q;
  assign irq           = irq_q;
  assign bus.io_rdata  = rdata_q;
  assign bus.io_rvalid = rvalid_q;

endmodule

// File: doc/mmio_hub.md
MMIO_HUB -- requirements
Module: mmio_hub

Parameters
REQ-001 NCH, default 3: number of I/O channels; legal range 1..8.
REQ-002 CH_W, default 8: bits per channel (LED and switch).
REQ-003 DB_CYCLES, default 4: consecutive stable cycles required to accept a switch value; legal range 1..65535.
REQ-004 AW, derived = clog2(NCH)+2: register address width.

Interface
REQ-005 clock  in  1  single clock; every flop is on its rising edge.
REQ-006 rst  in  1  synchronous reset, active-high.
REQ-007 io_cs  in  1  chip select; io_read and io_write are ignored while it is low.
REQ-008 io_read  in  1  read strobe, one request per cycle.
REQ-009 io_write  in  1  write strobe, one request per cycle.
REQ-010 io_addr  in  AW  register address, {channel, reg[1:0]}.
REQ-011 io_wdata  in  32  write data; only bits [CH_W-1:0] are used.
REQ-012 io_rdata  out  32  read data, zero-extended.
REQ-013 io_rvalid  out  1  one-cycle pulse qualifying io_rdata.
REQ-014 switch_i  in  NCH*CH_W  raw asynchronous switches; channel c occupies bits [c*CH_W +: CH_W].
REQ-015 leds_o  out  NCH*CH_W  LED drive, using the same packing as switch_i.
REQ-016 irq  out  1  level interrupt.

Function
REQ-017 Register map per channel c: reg 0 LED (RW); reg 1 SW, the debounced switch value (RO); reg 2 EDGE, sticky change flags (RW1C); reg 3 CTRL, where bit0 is the irq enable and bit1 makes leds_o mirror SW (RW).
REQ-018 Each switch_i bit passes through a 2-flop synchroniser before debounce.
REQ-019 Each channel has one stability counter. The counter clears whenever the synchronised value differs from the previous cycle's sample.
REQ-020 SW loads the sample once the sample has been stable for DB_CYCLES consecutive cycles. The counter saturates, so there is no wrap-around.
REQ-021 Minimum latency from a switch_i change to a SW update is 2 + DB_CYCLES cycles. A glitch shorter than DB_CYCLES cycles never reaches SW.
REQ-022 Any SW bit that changes value sets the matching EDGE bit in the same cycle as the SW update.
REQ-023 A write to EDGE clears the bits where io_wdata is 1. If a set and a clear hit the same bit in the same cycle, the set wins.
REQ-024 irq is registered: irq = OR over c of (CTRL[c].bit0 AND |EDGE[c]). It asserts one cycle after an EDGE bit sets, provided the channel is enabled.
REQ-025 leds_o channel c = SW[c] when CTRL[c].bit1 = 1, otherwise LED[c]. leds_o is driven from flops.
REQ-026 Read latency is 1 cycle: io_rdata and io_rvalid are registered. io_rvalid = 1 for exactly one cycle per accepted read.
REQ-027 io_rdata holds its value between reads.
REQ-028 A write updates the register on the clock edge where io_write is sampled high.
REQ-029 If a read and a write target the same register in the same cycle, the read returns the pre-write value.
REQ-030 A channel index >= NCH reads 0 and still pulses io_rvalid. Writes to it are ignored.
REQ-031 Writes to SW are ignored.
REQ-032 Upper bits of io_wdata above the register's width are ignored. CTRL bits [31:2] read as 0.

Reset
REQ-033 While rst = 1 the following are all 0: LED, SW, EDGE, CTRL, the stability counters, the synchroniser flops, leds_o, io_rdata, io_rvalid and irq.
REQ-034 A request presented in a cycle with rst = 1 is discarded, and no io_rvalid follows it.
REQ-035 Reset asserted mid-debounce abandons the count. After reset, a held switch value is accepted 2 + DB_CYCLES cycles after rst falls, and it sets the matching EDGE bits.

Verification
REQ-036 Basic write/read: NCH=3, CH_W=8. Write 0xA5 to ch1 reg0 -> leds_o[15:8] = 0xA5 one cycle later. Read ch1 reg0 -> io_rvalid pulses 1 cycle later with io_rdata = 0x000000A5.
REQ-037 Debounce: DB_CYCLES=4. Hold switch_i[7:0] = 0x0F from rst release -> SW0 = 0x0F after 6 cycles and EDGE0 = 0x0F. A 3-cycle pulse to 0xFF -> SW0 unchanged.
REQ-038 Interrupt: CTRL2 = 1, then toggle switch bit 16 and hold it -> irq rises 1 cycle after EDGE2 bit0 sets. Write 0x01 to EDGE2 -> irq = 0 the next cycle.
REQ-039 Set beats clear: a W1C of EDGE0 bit0 in the same cycle as a new SW0 bit0 change -> EDGE0 bit0 remains 1.
REQ-040 Mirror mode: CTRL0 = 2 with SW0 = 0x3C -> leds_o[7:0] = 0x3C regardless of LED0.
REQ-041 Boundaries: a read of channel 3 (NCH=3) -> io_rdata = 0 with io_rvalid = 1. Write plus read of the same LED register in one cycle -> the read returns the old value.
REQ-042 Reset mid-operation: rst pulsed mid-read -> no io_rvalid, and all outputs read 0.
